// File: rtl/e15_pkg.sv
// Shared definitions for the E15 run controller: widths, opcodes, FSM states
// and halt-cause codes.
package e15_pkg;
    localparam int PC_W    = 4;
    localparam int INSTR_W = 12;

    localparam logic [3:0] OP_JMP  = 4'b0000;
    localparam logic [3:0] OP_MOVI = 4'b1001;
    localparam logic [3:0] OP_ADDI = 4'b1011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_RUN,
        ST_STEP,
        ST_HALT
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_CMD   = 2'd0,
        CAUSE_BP    = 2'd1,
        CAUSE_LOOP  = 2'd2,
        CAUSE_LIMIT = 2'd3
    } cause_t;
endpackage

// File: rtl/e15_rom_loader.sv
// Host-side ROM write port: valid/ready handshake with a registered one-cycle
// write strobe and captured address/data.
module e15_rom_loader #(
    parameter int PC_W    = 4,
    parameter int INSTR_W = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               canLoad,
    input  logic               ld_valid,
    input  logic [PC_W-1:0]    ld_addr,
    input  logic [INSTR_W-1:0] ld_data,
    output logic               ld_ready,
    output logic               accepted,
    output logic               rom_we,
    output logic [PC_W-1:0]    rom_waddr,
    output logic [INSTR_W-1:0] rom_wdata
);
    assign ld_ready = canLoad;
    assign accepted = ld_valid & canLoad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_we    <= 1'b0;
            rom_waddr <= '0;
            rom_wdata <= '0;
        end else begin
            rom_we <= accepted;
            if (accepted) begin
                rom_waddr <= ld_addr;
                rom_wdata <= ld_data;
            end
        end
    end
endmodule

// File: rtl/e15_run_ctrl.sv
// Run/step/halt sequencer for the E15 core: gates instruction commit, clears
// the PC at program start and records why execution stopped.
module e15_run_ctrl #(
    parameter int PC_W    = e15_pkg::PC_W,
    parameter int INSTR_W = e15_pkg::INSTR_W,
    parameter int CYC_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [PC_W-1:0]    ld_addr,
    input  logic [INSTR_W-1:0] ld_data,
    output logic               rom_we,
    output logic [PC_W-1:0]    rom_waddr,
    output logic [INSTR_W-1:0] rom_wdata,
    input  logic               cmd_run,
    input  logic               cmd_step,
    input  logic               cmd_halt,
    input  logic               bp_en,
    input  logic [PC_W-1:0]    bp_addr,
    input  logic [PC_W-1:0]    core_pc,
    input  logic [3:0]         core_opcode,
    input  logic [3:0]         core_imm,
    output logic               core_en,
    output logic               core_pc_clr,
    output logic               busy,
    output logic               halted,
    output logic [1:0]         halt_cause,
    output logic [CYC_W-1:0]   cyc_cnt
);
    import e15_pkg::*;

    localparam logic [CYC_W-1:0] CYC_MAX  = '1;
    localparam logic [CYC_W-1:0] CYC_LAST = {{(CYC_W-1){1'b1}}, 1'b0};

    state_t           state, nextState;
    cause_t           causeQ, causeD;
    logic             pendStep, pendStepD;
    logic             resumeSkip, resumeSkipD;
    logic             clrCnt;
    logic             canLoad, accepted;
    logic             selfLoop, bpHit;
    logic [CYC_W-1:0] cycQ;

    assign canLoad  = (state == ST_IDLE) || (state == ST_HALT);
    assign selfLoop = (core_opcode == OP_JMP) && (core_imm == 4'd0);
    assign bpHit    = bp_en && (core_pc == bp_addr) && !resumeSkip;

    e15_rom_loader #(.PC_W(PC_W), .INSTR_W(INSTR_W)) uLoader (
        .clk       (clk),
        .rst_n     (rst_n),
        .canLoad   (canLoad),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .accepted  (accepted),
        .rom_we    (rom_we),
        .rom_waddr (rom_waddr),
        .rom_wdata (rom_wdata)
    );

    always_comb begin
        nextState   = state;
        causeD      = causeQ;
        pendStepD   = pendStep;
        resumeSkipD = resumeSkip;
        clrCnt      = 1'b0;
        core_en     = 1'b0;
        core_pc_clr = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_step) begin
                    nextState = ST_CLR;
                    pendStepD = 1'b1;
                end else if (cmd_run) begin
                    nextState = ST_CLR;
                    pendStepD = 1'b0;
                end
            end
            ST_CLR: begin
                core_pc_clr = 1'b1;
                clrCnt      = 1'b1;
                resumeSkipD = 1'b0;
                nextState   = pendStep ? ST_STEP : ST_RUN;
            end
            ST_RUN: begin
                // Stops are evaluated before the commit so the stopping
                // instruction is left for the next run/step.
                if (cmd_halt) begin
                    nextState = ST_HALT;
                    causeD    = CAUSE_CMD;
                end else if (selfLoop) begin
                    nextState = ST_HALT;
                    causeD    = CAUSE_LOOP;
                end else if (bpHit) begin
                    nextState = ST_HALT;
                    causeD    = CAUSE_BP;
                end else if (cycQ == CYC_MAX) begin
                    nextState = ST_HALT;
                    causeD    = CAUSE_LIMIT;
                end else begin
                    core_en     = 1'b1;
                    resumeSkipD = 1'b0;
                    if (cycQ == CYC_LAST) begin
                        nextState = ST_HALT;
                        causeD    = CAUSE_LIMIT;
                    end
                end
            end
            ST_STEP: begin
                core_en     = 1'b1;
                resumeSkipD = 1'b0;
                nextState   = ST_HALT;
                causeD      = CAUSE_CMD;
            end
            ST_HALT: begin
                // A fresh program load forces the next run to restart at PC 0.
                if (accepted) begin
                    nextState = ST_IDLE;
                end else if (cmd_step) begin
                    nextState = ST_STEP;
                end else if (cmd_run) begin
                    nextState   = ST_RUN;
                    resumeSkipD = 1'b1;
                end
            end
            default: nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            causeQ     <= CAUSE_CMD;
            pendStep   <= 1'b0;
            resumeSkip <= 1'b0;
            cycQ       <= '0;
        end else begin
            state      <= nextState;
            causeQ     <= causeD;
            pendStep   <= pendStepD;
            resumeSkip <= resumeSkipD;
            if (clrCnt)
                cycQ <= '0;
            else if (core_en && cycQ != CYC_MAX)
                cycQ <= cycQ + 1'b1;
        end
    end

    assign busy       = (state == ST_CLR) || (state == ST_RUN) || (state == ST_STEP);
    assign halted     = (state == ST_HALT);
    assign halt_cause = causeQ;
    assign cyc_cnt    = cycQ;
endmodule

// File: tb/tb_e15_run_ctrl.sv
// Directed bench for e15_run_ctrl with a behavioural core/ROM and scoreboards
// for ROM writes and halt events.
module tb_e15_run_ctrl;
    localparam int CW = 3;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          ld_valid = 1'b0, ld_ready;
    logic [3:0]    ld_addr = '0;
    logic [11:0]   ld_data = '0;
    logic          rom_we;
    logic [3:0]    rom_waddr;
    logic [11:0]   rom_wdata;
    logic          cmd_run = 1'b0, cmd_step = 1'b0, cmd_halt = 1'b0;
    logic          bp_en = 1'b0;
    logic [3:0]    bp_addr = '0;
    logic [3:0]    core_pc, core_opcode, core_imm;
    logic          core_en, core_pc_clr, busy, halted;
    logic [1:0]    halt_cause;
    logic [CW-1:0] cyc_cnt;

    e15_run_ctrl #(.CYC_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .rom_we(rom_we), .rom_waddr(rom_waddr), .rom_wdata(rom_wdata),
        .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_halt(cmd_halt),
        .bp_en(bp_en), .bp_addr(bp_addr),
        .core_pc(core_pc), .core_opcode(core_opcode), .core_imm(core_imm),
        .core_en(core_en), .core_pc_clr(core_pc_clr), .busy(busy), .halted(halted),
        .halt_cause(halt_cause), .cyc_cnt(cyc_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural core: jmp adds imm to the PC, everything else falls through.
    logic [11:0] rom [16];
    logic [3:0]  pcM;
    assign core_pc     = pcM;
    assign core_opcode = rom[pcM][11:8];
    assign core_imm    = rom[pcM][3:0];

    always @(posedge clk) if (rom_we) rom[rom_waddr] <= rom_wdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)           pcM <= '0;
        else if (core_pc_clr) pcM <= '0;
        else if (core_en)     pcM <= (core_opcode == 4'd0) ? pcM + core_imm : pcM + 4'd1;
    end

    int enCnt = 0, clrCnt = 0, weCnt = 0;
    always @(posedge clk) begin
        if (core_en)     enCnt <= enCnt + 1;
        if (core_pc_clr) clrCnt <= clrCnt + 1;
        if (rom_we)      weCnt <= weCnt + 1;
    end

    int nChk = 0, nPass = 0;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChk++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    typedef struct packed { logic [3:0] a; logic [11:0] d; } wr_t;
    wr_t wrQ[$];

    always @(negedge clk) begin
        wr_t e;
        if (rom_we) begin
            if (wrQ.size() == 0) begin
                check("rom_we_unexpected", 32'd1, 32'd0);
            end else begin
                e = wrQ.pop_front();
                check("rom_waddr", rom_waddr, e.a);
                check("rom_wdata", rom_wdata, e.d);
            end
        end
    end

    typedef struct { int cause; int cyc; int pc; int ens; } hx_t;
    hx_t hq[$];

    task automatic expectHalt(input int cause, input int cyc, input int pc, input int ens);
        hx_t e;
        e.cause = cause; e.cyc = cyc; e.pc = pc; e.ens = ens;
        hq.push_back(e);
    endtask

    task automatic waitHalt(input string tag, input int en0);
        int n = 0;
        hx_t e;
        while (!halted && n < 100) begin @(negedge clk); n++; end
        check({tag, "_halted"}, halted, 1);
        if (hq.size() == 0) begin
            check({tag, "_noexp"}, 32'd1, 32'd0);
        end else begin
            e = hq.pop_front();
            check({tag, "_cause"}, halt_cause, e.cause);
            check({tag, "_cyc"},   cyc_cnt,    e.cyc);
            check({tag, "_pc"},    core_pc,    e.pc);
            check({tag, "_ens"},   enCnt - en0, e.ens);
        end
    endtask

    task automatic load(input logic [3:0] a, input logic [11:0] d);
        wr_t e;
        @(negedge clk);
        check("ld_ready", ld_ready, 1);
        ld_valid = 1'b1; ld_addr = a; ld_data = d;
        e.a = a; e.d = d;
        wrQ.push_back(e);
    endtask

    task automatic ldDone();
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    task automatic runCmd(input int which);
        @(negedge clk);
        cmd_run = (which == 0); cmd_step = (which == 1);
        @(negedge clk);
        cmd_run = 1'b0; cmd_step = 1'b0;
    endtask

    initial begin
        int en0, c0, w0;
        repeat (2) @(negedge clk);
        check("rst_ld_ready", ld_ready, 1);
        check("rst_core_en", core_en, 0);
        check("rst_pc_clr", core_pc_clr, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_cause", halt_cause, 0);
        check("rst_cyc", cyc_cnt, 0);
        check("rst_rom_we", rom_we, 0);
        rst_n = 1'b1;

        // Program: movi, addi, jmp +0
        load(4'd0, 12'h912);
        load(4'd1, 12'hB01);
        load(4'd2, 12'h000);
        ldDone();
        repeat (2) @(negedge clk);
        check("load_we_count", weCnt, 3);
        check("load_q_empty", wrQ.size(), 0);
        check("load_ready_idle", ld_ready, 1);

        // Run from IDLE, stops on self-loop at PC 2
        en0 = enCnt; c0 = clrCnt;
        expectHalt(2, 2, 2, 2);
        runCmd(0);
        check("clr_pulse", core_pc_clr, 1);
        check("clr_no_en", core_en, 0);
        check("clr_busy", busy, 1);
        waitHalt("selfloop", en0);
        check("clr_count", clrCnt - c0, 1);
        check("halt_no_ready_drop", ld_ready, 1);

        // Breakpoint at PC 1; a load while halted returns to IDLE
        bp_en = 1'b1; bp_addr = 4'd1;
        load(4'd2, 12'h000);
        ldDone();
        check("load_halt_to_idle", halted, 0);
        en0 = enCnt;
        expectHalt(1, 1, 1, 1);
        runCmd(0);
        waitHalt("bp", en0);
        en0 = enCnt;
        expectHalt(2, 2, 2, 1);
        runCmd(0);
        waitHalt("bp_resume", en0);

        // Single steps from HALT
        en0 = enCnt;
        expectHalt(0, 3, 2, 1);
        runCmd(1);
        check("step_busy", busy, 1);
        waitHalt("step1", en0);
        en0 = enCnt;
        expectHalt(0, 4, 2, 1);
        runCmd(1);
        waitHalt("step2", en0);

        // Two-instruction loop hits the cycle limit (2^3-1 = 7)
        bp_en = 1'b0;
        load(4'd0, 12'hB01);
        load(4'd1, 12'h00F);
        ldDone();
        en0 = enCnt;
        expectHalt(3, 7, 1, 7);
        runCmd(0);
        waitHalt("limit", en0);
        en0 = enCnt;
        expectHalt(3, 7, 1, 0);
        runCmd(0);
        check("limit_again_no_en", core_en, 0);
        waitHalt("limit_again", en0);

        // Simultaneous halt and step in RUN: halt wins
        load(4'd0, 12'hB01);
        ldDone();
        en0 = enCnt;
        expectHalt(0, 1, 1, 1);
        runCmd(0);
        @(negedge clk);
        @(negedge clk);
        cmd_halt = 1'b1; cmd_step = 1'b1;
        #1 check("halt_step_no_en", core_en, 0);
        @(negedge clk);
        cmd_halt = 1'b0; cmd_step = 1'b0;
        waitHalt("halt_wins", en0);

        // Asynchronous reset in the middle of a run
        runCmd(0);
        check("pre_rst_en", core_en, 1);
        w0 = weCnt;
        rst_n = 1'b0;
        #1;
        check("mid_rst_en", core_en, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_halted", halted, 0);
        check("mid_rst_ready", ld_ready, 1);
        check("mid_rst_cyc", cyc_cnt, 0);
        check("mid_rst_cause", halt_cause, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_no_we", weCnt - w0, 0);
        check("post_rst_idle", busy, 0);

        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end
endmodule
